// File: rtl/array_eyeriss_feeder.sv
// ----------------------------------------------------------------------------
// array_eyeriss_feeder
//
// Tile sequencer and stream front-end for an Eyeriss-style systolic array.
// Unskewed per-step ifm/weight vectors come in over a valid/ready handshake.
// The block launches them into the array's row and column ports with one
// cycle of skew per lane, waits for the wavefront to flush, and then drains
// HEIGHT result rows from the array's ofm port onto an output stream.
//
// Sequence per tile: IDLE -> CLR (1 cycle) -> FEED (cfg_k accepts)
//                    -> FLUSH (HEIGHT+WIDTH cycles) -> DRAIN (HEIGHT beats)
//
// Compile-time option:
//   ARRAY_FEEDER_SKEW_EN  defined   : internal skew shift registers; row h
//                                     and column w see a launch h / w cycles
//                                     after the accept.
//                         undefined : every lane is driven straight from the
//                                     launch in the accept cycle (the caller
//                                     pre-skews its data).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, cfg_k          begin a tile with cfg_k accumulation steps (IDLE only)
//   busy, done            not-IDLE flag, one-cycle end-of-tile pulse
//   in_valid, in_ready    step handshake
//   in_ifm, in_wght       unskewed step vectors (HEIGHT / WIDTH lanes)
//   arr_en_i, arr_clr_i   per-row enable / clear to the array
//   arr_ifm               per-row operand to the array
//   arr_en_w, arr_clr_w   per-column enable / clear to the array
//   arr_wght              per-column operand to the array
//   arr_en_o, arr_clr_o   output-chain shift enable / clear to the array
//   arr_ofm               array row-0 column results
//   out_valid, out_ready  result handshake
//   out_ofm               one drained result row
// ----------------------------------------------------------------------------
module array_eyeriss_feeder #(
    parameter int HEIGHT = 12,
    parameter int WIDTH  = 14,
    parameter int IWIDTH = 16,
    parameter int OWIDTH = 32,
    parameter int KW     = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [KW-1:0]                         cfg_k,
    output logic                                  busy,
    output logic                                  done,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic signed [HEIGHT-1:0][IWIDTH-1:0]  in_ifm,
    input  logic signed [WIDTH-1:0][IWIDTH-1:0]   in_wght,
    output logic [HEIGHT-1:0]                     arr_en_i,
    output logic [HEIGHT-1:0]                     arr_clr_i,
    output logic signed [HEIGHT-1:0][IWIDTH-1:0]  arr_ifm,
    output logic [WIDTH-1:0]                      arr_en_w,
    output logic [WIDTH-1:0]                      arr_clr_w,
    output logic signed [WIDTH-1:0][IWIDTH-1:0]   arr_wght,
    output logic [WIDTH-1:0]                      arr_en_o,
    output logic [WIDTH-1:0]                      arr_clr_o,
    input  logic signed [WIDTH-1:0][OWIDTH-1:0]   arr_ofm,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic signed [WIDTH-1:0][OWIDTH-1:0]   out_ofm
);

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int FLUSH_LEN = HEIGHT + WIDTH;
    localparam int FW        = $clog2(FLUSH_LEN + 1);
    localparam int DW        = $clog2(HEIGHT + 1);

    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);
    localparam logic [DW-1:0] BEAT_LAST  = DW'(HEIGHT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state;
    logic [KW-1:0]   k_cnt;      // accepted steps in this tile
    logic [KW-1:0]   k_last;     // cfg_k - 1, latched at start
    logic [FW-1:0]   flush_cnt;
    logic [DW-1:0]   beat_cnt;

    logic            accept;     // step handshake completes this cycle
    logic            beat;       // result handshake completes this cycle

    assign accept = in_valid & in_ready;
    assign beat   = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Tile sequencer. in_ready / out_valid / done are registered and
    // move together with the state so no output depends on a decode of
    // the next state.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            k_cnt     <= '0;
            k_last    <= '0;
            flush_cnt <= '0;
            beat_cnt  <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    // A zero-step tile has nothing to accumulate: ignore it.
                    if (start && (cfg_k != '0)) begin
                        k_last <= cfg_k - 1'b1;
                        k_cnt  <= '0;
                        state  <= ST_CLR;
                    end
                end

                ST_CLR: begin
                    in_ready <= 1'b1;
                    state    <= ST_FEED;
                end

                ST_FEED: begin
                    if (accept) begin
                        if (k_cnt == k_last) begin
                            // k stops at cfg_k-1; it is never incremented
                            // past the last step, so cfg_k = 2^KW-1 is safe.
                            in_ready  <= 1'b0;
                            flush_cnt <= '0;
                            state     <= ST_FLUSH;
                        end else begin
                            k_cnt <= k_cnt + 1'b1;
                        end
                    end
                end

                ST_FLUSH: begin
                    // Long enough for the last skewed step to reach the far
                    // corner of the array and for its result to settle.
                    if (flush_cnt == FLUSH_LAST) begin
                        out_valid <= 1'b1;
                        beat_cnt  <= '0;
                        state     <= ST_DRAIN;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (beat) begin
                        if (beat_cnt == BEAT_LAST) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    // ------------------------------------------------------------------
    // Output chain control and result stream.
    // The output chain only shifts on an accepted beat, so arr_ofm (and
    // therefore out_ofm) stays put while the consumer stalls.
    // ------------------------------------------------------------------
    assign arr_clr_o = {WIDTH{state == ST_CLR}};
    assign arr_en_o  = {WIDTH{beat}};
    assign out_ofm   = out_valid ? arr_ofm : '0;

    // ------------------------------------------------------------------
    // Launch point: what lane 0 sees this cycle. Operands are held at the
    // last accepted value during bubbles so the array inputs do not toggle
    // needlessly while enables are low.
    // ------------------------------------------------------------------
    logic                                 launch_en;
    logic                                 launch_clr;
    logic signed [HEIGHT-1:0][IWIDTH-1:0] launch_ifm;
    logic signed [WIDTH-1:0][IWIDTH-1:0]  launch_wght;
    logic signed [HEIGHT-1:0][IWIDTH-1:0] held_ifm;
    logic signed [WIDTH-1:0][IWIDTH-1:0]  held_wght;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_ifm  <= '0;
            held_wght <= '0;
        end else if (accept) begin
            held_ifm  <= in_ifm;
            held_wght <= in_wght;
        end
    end

    // Only the first step of a tile clears the accumulators, replacing the
    // stale partial sums with the first product.
    assign launch_en   = accept;
    assign launch_clr  = accept && (k_cnt == '0);
    assign launch_ifm  = accept ? in_ifm  : held_ifm;
    assign launch_wght = accept ? in_wght : held_wght;

`ifdef ARRAY_FEEDER_SKEW_EN
    // ------------------------------------------------------------------
    // Skew: lane n is the launch delayed by n cycles through its own
    // shift register of depth n; lane 0 is taken straight from the launch.
    // ------------------------------------------------------------------
    for (genvar h = 0; h < HEIGHT; h++) begin : g_row
        if (h == 0) begin : g_direct
            assign arr_en_i[0]  = launch_en;
            assign arr_clr_i[0] = launch_clr;
            assign arr_ifm[0]   = launch_ifm[0];
        end else begin : g_skew
            logic [h-1:0]             en_sr;
            logic [h-1:0]             clr_sr;
            logic [h-1:0][IWIDTH-1:0] dat_sr;

            // NOTE: skew stages are reset so a tile aborted by rst_n cannot
            // leave stray enables/clears marching into the array afterwards.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    en_sr  <= '0;
                    clr_sr <= '0;
                    dat_sr <= '0;
                end else begin
                    en_sr[0]  <= launch_en;
                    clr_sr[0] <= launch_clr;
                    dat_sr[0] <= launch_ifm[h];
                    for (int i = 1; i < h; i++) begin
                        en_sr[i]  <= en_sr[i-1];
                        clr_sr[i] <= clr_sr[i-1];
                        dat_sr[i] <= dat_sr[i-1];
                    end
                end
            end

            assign arr_en_i[h]  = en_sr[h-1];
            assign arr_clr_i[h] = clr_sr[h-1];
            assign arr_ifm[h]   = dat_sr[h-1];
        end
    end

    for (genvar w = 0; w < WIDTH; w++) begin : g_col
        if (w == 0) begin : g_direct
            assign arr_en_w[0]  = launch_en;
            assign arr_clr_w[0] = launch_clr;
            assign arr_wght[0]  = launch_wght[0];
        end else begin : g_skew
            logic [w-1:0]             en_sr;
            logic [w-1:0]             clr_sr;
            logic [w-1:0][IWIDTH-1:0] dat_sr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    en_sr  <= '0;
                    clr_sr <= '0;
                    dat_sr <= '0;
                end else begin
                    en_sr[0]  <= launch_en;
                    clr_sr[0] <= launch_clr;
                    dat_sr[0] <= launch_wght[w];
                    for (int i = 1; i < w; i++) begin
                        en_sr[i]  <= en_sr[i-1];
                        clr_sr[i] <= clr_sr[i-1];
                        dat_sr[i] <= dat_sr[i-1];
                    end
                end
            end

            assign arr_en_w[w]  = en_sr[w-1];
            assign arr_clr_w[w] = clr_sr[w-1];
            assign arr_wght[w]  = dat_sr[w-1];
        end
    end
`else
    // ------------------------------------------------------------------
    // No internal skew: every lane sees the launch in the accept cycle.
    // ------------------------------------------------------------------
    assign arr_en_i  = {HEIGHT{launch_en}};
    assign arr_clr_i = {HEIGHT{launch_clr}};
    assign arr_ifm   = launch_ifm;
    assign arr_en_w  = {WIDTH{launch_en}};
    assign arr_clr_w = {WIDTH{launch_clr}};
    assign arr_wght  = launch_wght;
`endif

endmodule

// File: tb/tb_array_eyeriss_feeder.sv
// ----------------------------------------------------------------------------
// tb_array_eyeriss_feeder
//
// Drives randomized tiles into array_eyeriss_feeder (HEIGHT=3, WIDTH=4) and
// compares every output every cycle against a reference model built from the
// tile timeline: CLR the cycle after start, FEED until cfg_k accepts, a fixed
// HEIGHT+WIDTH flush, then HEIGHT result beats. Lane expectations come from a
// log of accepted steps: lane n shows the step accepted n cycles earlier
// (0 cycles when the skew option is off). A small array stub supplies result
// rows and advances one row per arr_en_o pulse.
// ----------------------------------------------------------------------------
module tb_array_eyeriss_feeder;

    localparam int H  = 3;
    localparam int W  = 4;
    localparam int IW = 16;
    localparam int OW = 32;
    localparam int KW = 16;
    localparam int TILE_LIMIT = 2000;

`ifdef ARRAY_FEEDER_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [KW-1:0]        cfg_k;
    logic                 busy, done;
    logic                 in_valid, in_ready;
    logic [H-1:0][IW-1:0] in_ifm;
    logic [W-1:0][IW-1:0] in_wght;
    logic [H-1:0]         arr_en_i, arr_clr_i;
    logic [H-1:0][IW-1:0] arr_ifm;
    logic [W-1:0]         arr_en_w, arr_clr_w;
    logic [W-1:0][IW-1:0] arr_wght;
    logic [W-1:0]         arr_en_o, arr_clr_o;
    logic [W-1:0][OW-1:0] arr_ofm;
    logic                 out_valid, out_ready;
    logic [W-1:0][OW-1:0] out_ofm;

    always #5 clk = ~clk;

    array_eyeriss_feeder #(
        .HEIGHT(H), .WIDTH(W), .IWIDTH(IW), .OWIDTH(OW), .KW(KW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_k(cfg_k),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ifm(in_ifm), .in_wght(in_wght),
        .arr_en_i(arr_en_i), .arr_clr_i(arr_clr_i), .arr_ifm(arr_ifm),
        .arr_en_w(arr_en_w), .arr_clr_w(arr_clr_w), .arr_wght(arr_wght),
        .arr_en_o(arr_en_o), .arr_clr_o(arr_clr_o), .arr_ofm(arr_ofm),
        .out_valid(out_valid), .out_ready(out_ready), .out_ofm(out_ofm)
    );

    // ------------------------------------------------------------------
    // Array stub: HEIGHT result rows, pointer reset by clear, advanced by
    // an all-ones output enable.
    // ------------------------------------------------------------------
    logic [W-1:0][OW-1:0] stub_rows [H];
    int                   stub_ptr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          stub_ptr <= 0;
        else if (&arr_clr_o) stub_ptr <= 0;
        else if (&arr_en_o)  stub_ptr <= stub_ptr + 1;
    end

    assign arr_ofm = (stub_ptr < H) ? stub_rows[stub_ptr] : '0;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int                   cyc;
        int                   k;
        logic [H-1:0][IW-1:0] ifm;
        logic [W-1:0][IW-1:0] wg;
    } step_t;

    step_t steps[$];
    int    cyc = 0;
    bit    active;
    int    t_start, kcfg, n_acc, n_beats, last_acc, done_cyc;
    int    dut_done_cyc, feed_cycles, en_o_pulses;
    bit    tog, bubbled;

    function automatic bit ph_clr();
        return active && (cyc == t_start + 1);
    endfunction
    function automatic bit ph_feed();
        return active && (cyc > t_start + 1) && (n_acc < kcfg);
    endfunction
    function automatic bit ph_flush();
        return active && (n_acc == kcfg) && (cyc <= last_acc + H + W);
    endfunction
    function automatic bit ph_drain();
        return active && (n_acc == kcfg) && (cyc > last_acc + H + W);
    endfunction

    task automatic model_reset();
        active   = 1'b0;
        steps.delete();
        n_acc    = 0;
        n_beats  = 0;
        kcfg     = 0;
        t_start  = -100;
        last_acc = -100;
        done_cyc = -1;
    endtask

    task automatic model_update();
        bit f, d;
        step_t s;
        f = ph_feed();
        d = ph_drain();
        if (!active) begin
            if (start && cfg_k != '0) begin
                active  = 1'b1;
                t_start = cyc;
                kcfg    = int'(cfg_k);
                n_acc   = 0;
                n_beats = 0;
            end
        end else if (f && in_valid) begin
            s.cyc = cyc; s.k = n_acc; s.ifm = in_ifm; s.wg = in_wght;
            steps.push_back(s);
            if (steps.size() > 2 * (H + W)) steps.delete(0);
            n_acc++;
            if (n_acc == kcfg) last_acc = cyc;
        end else if (d && out_ready) begin
            n_beats++;
            if (n_beats == H) begin
                active   = 1'b0;
                done_cyc = cyc + 1;
            end
        end
        cyc++;
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic check_cycle();
        step_t                cand[$];
        step_t                cur;
        logic [H-1:0]         e_en_i, e_clr_i;
        logic [H-1:0][IW-1:0] e_ifm;
        logic [W-1:0]         e_en_w, e_clr_w;
        logic [W-1:0][IW-1:0] e_wg;
        logic [W-1:0][OW-1:0] e_ofm;

        cand = steps;
        if (ph_feed() && in_valid) begin
            cur.cyc = cyc; cur.k = n_acc; cur.ifm = in_ifm; cur.wg = in_wght;
            cand.push_back(cur);
        end
        for (int h = 0; h < H; h++) begin
            int t;
            t = cyc - (SKEW ? h : 0);
            e_en_i[h] = 1'b0; e_clr_i[h] = 1'b0; e_ifm[h] = '0;
            foreach (cand[i]) if (cand[i].cyc <= t) begin
                e_ifm[h]   = cand[i].ifm[h];
                e_en_i[h]  = (cand[i].cyc == t);
                e_clr_i[h] = (cand[i].cyc == t) && (cand[i].k == 0);
            end
        end
        for (int w = 0; w < W; w++) begin
            int t;
            t = cyc - (SKEW ? w : 0);
            e_en_w[w] = 1'b0; e_clr_w[w] = 1'b0; e_wg[w] = '0;
            foreach (cand[i]) if (cand[i].cyc <= t) begin
                e_wg[w]    = cand[i].wg[w];
                e_en_w[w]  = (cand[i].cyc == t);
                e_clr_w[w] = (cand[i].cyc == t) && (cand[i].k == 0);
            end
        end
        e_ofm = '0;
        if (ph_drain()) e_ofm = stub_rows[n_beats];

        check("busy",      {busy},      {active});
        check("in_ready",  {in_ready},  {ph_feed()});
        check("out_valid", {out_valid}, {ph_drain()});
        check("done",      {done},      {cyc == done_cyc});
        check("arr_clr_o", {arr_clr_o}, {W{ph_clr()}});
        check("arr_en_o",  {arr_en_o},  {W{ph_drain() && out_ready}});
        check("out_ofm",   {out_ofm},   {e_ofm});
        check("arr_en_i",  {arr_en_i},  {e_en_i});
        check("arr_clr_i", {arr_clr_i}, {e_clr_i});
        check("arr_ifm",   {arr_ifm},   {e_ifm});
        check("arr_en_w",  {arr_en_w},  {e_en_w});
        check("arr_clr_w", {arr_clr_w}, {e_clr_w});
        check("arr_wght",  {arr_wght},  {e_wg});

        if (done)      dut_done_cyc = cyc;
        if (in_ready)  feed_cycles++;
        if (&arr_en_o) en_o_pulses++;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    // One clock cycle: drive inputs just after the edge, check at the
    // falling edge, advance the model at the next rising edge.
    task automatic tick(input bit s, input int k, input bit v, input bit r);
        logic [31:0] rnd;
        start     = s;
        cfg_k     = k[KW-1:0];
        in_valid  = v;
        out_ready = r;
        for (int h = 0; h < H; h++) begin rnd = $urandom; in_ifm[h]  = rnd[IW-1:0]; end
        for (int w = 0; w < W; w++) begin rnd = $urandom; in_wght[w] = rnd[IW-1:0]; end
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic load_stub();
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++)
                stub_rows[i][j] = $urandom;
    endtask

    // vmode: 0 always valid, 1 random, 2 single bubble after step 0
    // rmode: 0 always ready, 1 toggling 1,0,1,..., 2 random
    // noise: assert start with random cfg_k while the tile is running
    task automatic run_tile(input int k, input int vmode, input int rmode, input bit noise);
        int guard;
        bit v, r, s;
        int nk;
        load_stub();
        feed_cycles = 0;
        en_o_pulses = 0;
        tog         = 1'b1;
        bubbled     = 1'b0;
        tick(1'b1, k, 1'b1, 1'b1);
        guard = 0;
        while (active && guard < TILE_LIMIT) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = ($urandom_range(0, 3) != 0);
                default: begin
                    v = !(ph_feed() && n_acc == 1 && !bubbled);
                    if (!v) bubbled = 1'b1;
                end
            endcase
            case (rmode)
                0: r = 1'b1;
                1: begin
                    r = ph_drain() ? tog : 1'b1;
                    if (ph_drain()) tog = ~tog;
                end
                default: r = ($urandom_range(0, 2) != 0);
            endcase
            s  = noise && ($urandom_range(0, 2) == 0);
            nk = $urandom_range(0, 5);
            tick(s, nk, v, r);
            guard++;
        end
        if (guard >= TILE_LIMIT) check("tile_timeout", guard, 0);
        // Cycle in which done is expected and the block is back in IDLE.
        tick(1'b0, 0, 1'b0, 1'b1);
        check("tile_idle", {busy}, 1'b0);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0; start = 1'b0; cfg_k = '0;
        in_valid = 1'b0; out_ready = 1'b0; in_ifm = '0; in_wght = '0;
        for (int i = 0; i < H; i++) stub_rows[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctl",  {busy, done, in_ready, out_valid, arr_en_i, arr_clr_i,
                             arr_en_w, arr_clr_w, arr_en_o, arr_clr_o}, '0);
        check("reset_data", {arr_ifm, arr_wght, out_ofm}, '0);
        rst_n = 1'b1;

        // Single-step tile, no stalls: minimum latency.
        run_tile(1, 0, 0, 1'b0);
        check("latency_k1", dut_done_cyc - t_start, 1 + 1 + 1 + H + W + H);

        // Three steps with one bubble: FEED spans four cycles.
        run_tile(3, 2, 0, 1'b0);
        check("feed_len_bubble", feed_cycles, 4);

        // Consumer toggling ready during DRAIN: exactly HEIGHT shifts.
        run_tile(2, 0, 1, 1'b0);
        check("drain_pulses", en_o_pulses, H);

        // start with cfg_k = 0 is ignored; stray starts during a tile too.
        repeat (3) tick(1'b1, 0, 1'b1, 1'b1);
        run_tile(4, 1, 0, 1'b1);

        // Reset in the middle of FLUSH.
        load_stub();
        tick(1'b1, 2, 1'b1, 1'b1);
        for (int g = 0; g < 20 && !ph_flush(); g++) tick(1'b0, 0, 1'b1, 1'b1);
        tick(1'b0, 0, 1'b0, 1'b1);
        check("flush_reached", {busy, in_ready, out_valid}, 3'b100);
        rst_n = 1'b0;
        #1;
        check("rst_async_ctl",  {busy, done, in_ready, out_valid, arr_en_i, arr_clr_i,
                                 arr_en_w, arr_clr_w, arr_en_o, arr_clr_o}, '0);
        check("rst_async_data", {arr_ifm, arr_wght, out_ofm}, '0);
        model_reset();
        @(posedge clk); cyc++;
        #1;
        rst_n = 1'b1;
        run_tile(2, 0, 0, 1'b0);

        // Randomized tiles.
        repeat (12) run_tile($urandom_range(1, 7), 1, 2, 1'b1);
        run_tile(20, 1, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
